store_sequencer: RTL

- Synthesizable control-step sequencer for the store instruction (st Ra, C(Rb)). It is the write-direction counterpart of the load step sequence.
- Drives Datapath control strobes through fetch, effective-address compute, MDR load from bus, and memory write.
- Handshakes with memory via Mem_ready, stretching fetch-read and store-write steps for wait states.
- Sits between the top-level controller (Start/Done) and the Datapath control inputs.

---
 rtl/store_seq_pkg.sv | 72 +++++++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/store_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/store_seq_pkg.sv
// Shared types and constants for the store instruction step sequencer.
// Holds the state encoding, the default wait limit, and the datapath strobe decode.
package store_seq_pkg;

  localparam int unsigned WAIT_MAX_DEFAULT = 15;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_DONE = 4'd8
  } state_e;

  localparam int unsigned NUM_CTL     = 17;
  localparam int unsigned CTL_PCOUT   = 0;
  localparam int unsigned CTL_INCPC   = 1;
  localparam int unsigned CTL_MARIN   = 2;
  localparam int unsigned CTL_ZIN     = 3;
  localparam int unsigned CTL_ZLOWOUT = 4;
  localparam int unsigned CTL_PCIN    = 5;
  localparam int unsigned CTL_READ    = 6;
  localparam int unsigned CTL_MDRIN   = 7;
  localparam int unsigned CTL_MDROUT  = 8;
  localparam int unsigned CTL_IRIN    = 9;
  localparam int unsigned CTL_GRB     = 10;
  localparam int unsigned CTL_GRA     = 11;
  localparam int unsigned CTL_BAOUT   = 12;
  localparam int unsigned CTL_ROUT    = 13;
  localparam int unsigned CTL_YIN     = 14;
  localparam int unsigned CTL_COUT    = 15;
  localparam int unsigned CTL_WRITE   = 16;

  typedef logic [NUM_CTL-1:0] ctl_t;

  // PCin is only raised on the first T1 cycle so a stretched fetch loads PC once.
  function automatic ctl_t state_strobes(state_e s, logic first_cycle);
    ctl_t c;
    c = '0;
    case (s)
      ST_T0: begin
        c[CTL_PCOUT] = 1'b1; c[CTL_MARIN] = 1'b1; c[CTL_INCPC] = 1'b1; c[CTL_ZIN] = 1'b1;
      end
      ST_T1: begin
        c[CTL_ZLOWOUT] = 1'b1; c[CTL_READ] = 1'b1; c[CTL_MDRIN] = 1'b1;
        c[CTL_PCIN]    = first_cycle;
      end
      ST_T2: begin
        c[CTL_MDROUT] = 1'b1; c[CTL_IRIN] = 1'b1;
      end
      ST_T3: begin
        c[CTL_GRB] = 1'b1; c[CTL_BAOUT] = 1'b1; c[CTL_YIN] = 1'b1;
      end
      ST_T4: begin
        c[CTL_COUT] = 1'b1; c[CTL_ZIN] = 1'b1;
      end
      ST_T5: begin
        c[CTL_ZLOWOUT] = 1'b1; c[CTL_MARIN] = 1'b1;
      end
      ST_T6: begin
        c[CTL_GRA] = 1'b1; c[CTL_ROUT] = 1'b1; c[CTL_MDRIN] = 1'b1; c[CTL_WRITE] = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory wait-cycle counter with synchronous clear and a terminal flag.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/store_sequencer.sv
// Control-step sequencer for st Ra, C(Rb): fetch, address compute, MDR load, memory write.
// Define STORE_SEQ_PERF_EN to add the Wait_count / Insn_count performance counters.
module store_sequencer
  import store_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int unsigned STEP_W   = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mem_ready,
  output logic              PCout,
  output logic              IncPC,
  output logic              MARin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Grb,
  output logic              Gra,
  output logic              BAout,
  output logic              Rout,
  output logic              Yin,
  output logic              Cout,
  output logic              Write,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [STEP_W-1:0] Step
`ifdef STORE_SEQ_PERF_EN
  ,
  output logic [15:0]       Wait_count,
  output logic [15:0]       Insn_count
`endif
);

  state_e state, state_next;
  logic   first_cycle;
  logic   mem_step, terminal, timeout, waiting;
  ctl_t   ctl;

  assign mem_step = (state == ST_T1) || (state == ST_T6);
  assign timeout  = mem_step && terminal;
  assign waiting  = mem_step && !Mem_ready && !timeout;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (state_next != state),
    .enable   (waiting),
    .terminal (terminal)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      first_cycle <= 1'b0;
    end else begin
      state       <= state_next;
      first_cycle <= (state_next != state);
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (Start) state_next = ST_T0;
      ST_T0:   state_next = ST_T1;
      ST_T1: begin
        if (timeout)        state_next = ST_IDLE;
        else if (Mem_ready) state_next = ST_T2;
      end
      ST_T2:   state_next = ST_T3;
      ST_T3:   state_next = ST_T4;
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = ST_T6;
      ST_T6: begin
        if (timeout)        state_next = ST_IDLE;
        else if (Mem_ready) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The timeout cycle silences every strobe; it depends only on registered state and count.
  assign ctl = timeout ? '0 : state_strobes(state, first_cycle);

  assign PCout   = ctl[CTL_PCOUT];
  assign IncPC   = ctl[CTL_INCPC];
  assign MARin   = ctl[CTL_MARIN];
  assign Zin     = ctl[CTL_ZIN];
  assign Zlowout = ctl[CTL_ZLOWOUT];
  assign PCin    = ctl[CTL_PCIN];
  assign Read    = ctl[CTL_READ];
  assign MDRin   = ctl[CTL_MDRIN];
  assign MDRout  = ctl[CTL_MDROUT];
  assign IRin    = ctl[CTL_IRIN];
  assign Grb     = ctl[CTL_GRB];
  assign Gra     = ctl[CTL_GRA];
  assign BAout   = ctl[CTL_BAOUT];
  assign Rout    = ctl[CTL_ROUT];
  assign Yin     = ctl[CTL_YIN];
  assign Cout    = ctl[CTL_COUT];
  assign Write   = ctl[CTL_WRITE];

  assign Busy  = (state != ST_IDLE) && (state != ST_DONE);
  assign Done  = (state == ST_DONE);
  assign Error = timeout;
  assign Step  = STEP_W'(state);

`ifdef STORE_SEQ_PERF_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Wait_count <= '0;
      Insn_count <= '0;
    end else begin
      if (waiting && (Wait_count != 16'hFFFF)) Wait_count <= Wait_count + 16'd1;
      if (Done)                                Insn_count <= Insn_count + 16'd1;
    end
  end
`endif

endmodule
